// File: rtl/step_counter_arbiter.sv
// Round-robin arbiter and burst sequencer for one shared step counter.
// A granted requester receives exactly req_len enable cycles on x_out.
// After the burst, done pulses for one cycle to that requester. Arbitration
// is non-preemptive: req and req_len are sampled only while idle.
module step_counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic [3:0]              state_in,
  output logic                    x_out,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [NREQ-1:0]         done,
  output logic                    wrap
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;

  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [LEN_W-1:0]   pick_len;
  logic [NREQ-1:0]    pick_onehot;
  int                 idx;

  // Round-robin search: first asserted request after the last winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  assign pick_len = req_len[pick*LEN_W +: LEN_W];

  // One-hot form of the winner, and done gated per requester by DONE.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign pick_onehot[gi] = (pick == PTR_W'(gi));
      assign done[gi]        = (state_q == DONE) & grant_q[gi];
    end
  endgenerate

  // Next-state logic: arbitrate in IDLE, count down in RUN, release in DONE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick_onehot;
          rem_d   = pick_len;
          win_d   = pick;
          // A zero-length request skips RUN but still gets its done pulse.
          state_d = (pick_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The finished owner becomes lowest priority for the next round.
        ptr_d   = win_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rem_q   <= '0;
      ptr_q   <= PTR_W'(NREQ - 1);
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign x_out = (state_q == RUN);
  assign busy  = (state_q != IDLE);
  assign grant = grant_q;
  assign wrap  = x_out & (state_in == 4'b1110);

endmodule

// File: tb/tb_step_counter_arbiter.sv
// Bench for step_counter_arbiter: a timestamp-based burst model checked
// every cycle, plus directed scenarios with hand-computed totals.
module tb_step_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int LEN_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [3:0]            cnt;
  logic                  x_out;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic                  wrap;

  logic                  preset_en;
  logic [3:0]            preset_val;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one burst described by its arbitration edge, length and owner.
  int ecnt     = 0;
  bit m_valid  = 1'b0;
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_len    = 0;
  int m_own    = 0;
  int m_next   = 0;
  int m_last   = NREQ - 1;

  // Observed tallies used by the directed checks.
  int x_total    = 0;
  int wrap_total = 0;
  int done_tot[NREQ];
  int done_q[$];

  always #5 clk = ~clk;

  step_counter_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_len  (req_len),
    .state_in (cnt),
    .x_out    (x_out),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  // Counter environment and arbitration model, both updated on rising edges.
  initial begin
    int w;
    bit f;
    cnt = 4'd0;
    forever begin
      @(posedge clk);
      ecnt++;
      if (rst) cnt = 4'd0;
      else if (preset_en) cnt = preset_val;
      else if (x_out) cnt = cnt + 4'd2;

      if (rst) begin
        m_valid  = 1'b1;
        m_active = 1'b0;
        m_next   = ecnt + 1;
        m_last   = NREQ - 1;
      end else if (m_valid && ecnt >= m_next && req != '0) begin
        f = 1'b0;
        w = 0;
        for (int j = 1; j <= NREQ; j++) begin
          if (!f && req[(m_last + j) % NREQ]) begin
            f = 1'b1;
            w = (m_last + j) % NREQ;
          end
        end
        m_active = 1'b1;
        m_k      = ecnt;
        m_len    = int'(req_len[w*LEN_W +: LEN_W]);
        m_own    = w;
        m_last   = w;
        m_next   = ecnt + m_len + 2;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    logic [NREQ-1:0] e_grant;
    logic            e_x;
    logic [NREQ-1:0] e_done;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        e_grant = '0;
        e_x     = 1'b0;
        e_done  = '0;
        if (m_active && ecnt >= m_k && ecnt <= m_k + m_len) begin
          e_grant = NREQ'(1) << m_own;
          e_x     = (ecnt < m_k + m_len);
          if (ecnt == m_k + m_len) e_done = e_grant;
        end
        check("grant", 32'(grant), 32'(e_grant));
        check("x_out", 32'(x_out), 32'(e_x));
        check("done",  32'(done),  32'(e_done));
        check("busy",  32'(busy),  32'(e_grant != '0));
        check("wrap",  32'(wrap),  32'(e_x && cnt == 4'b1110));
        if (x_out) x_total++;
        if (wrap)  wrap_total++;
        for (int i = 0; i < NREQ; i++) begin
          if (done[i]) begin
            done_tot[i]++;
            done_q.push_back(i);
            $display("burst done: requester %0d at edge %0d, counter %b", i, ecnt, cnt);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  // Directed scenarios.
  initial begin
    int x0, d0, w0, q0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) done_tot[i] = 0;
    rst        = 1'b1;
    req        = '0;
    req_len    = '0;
    preset_en  = 1'b0;
    preset_val = 4'd0;
    tick(2);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_xout",  32'(x_out), 32'd0);
    rst = 1'b0;

    // Single burst of 3 from requester 0.
    x0 = x_total; d0 = done_tot[0];
    set_len(0, 3); req = 4'b0001;
    tick(1); req = '0;
    tick(7);
    check("t1_xcycles", 32'(x_total - x0), 32'd3);
    check("t1_done0",   32'(done_tot[0] - d0), 32'd1);
    check("t1_count",   32'(cnt), 32'b0110);

    // All requesting, length 1: rotation 0,1,2,3,0 starting fresh from reset.
    rst = 1'b1; tick(1); rst = 1'b0;
    q0 = done_q.size(); x0 = x_total;
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req = 4'b1111;
    tick(13); req = '0;
    tick(5);
    check("t2_bursts", 32'(done_q.size() - q0), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (q0 + i < done_q.size()) check("t2_order", 32'(done_q[q0 + i]), 32'(exp_order[i]));
    end
    check("t2_xcycles", 32'(x_total - x0), 32'd5);

    // Zero-length request from requester 2.
    x0 = x_total; d0 = done_tot[2];
    set_len(2, 0); req = 4'b0100;
    tick(1); req = '0;
    tick(3);
    check("t3_xcycles", 32'(x_total - x0), 32'd0);
    check("t3_done2",   32'(done_tot[2] - d0), 32'd1);

    // Counter wrap: start at 1100, three steps.
    preset_val = 4'b1100; preset_en = 1'b1;
    tick(1); preset_en = 1'b0;
    x0 = x_total; w0 = wrap_total;
    set_len(0, 3); req = 4'b0001;
    tick(1); req = '0;
    tick(6);
    check("t4_wraps",   32'(wrap_total - w0), 32'd1);
    check("t4_xcycles", 32'(x_total - x0), 32'd3);
    check("t4_count",   32'(cnt), 32'b0010);

    // Reset during the second RUN cycle of a length-5 burst.
    x0 = x_total; d0 = done_tot[0];
    set_len(0, 5); req = 4'b0001;
    tick(1); req = '0;
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0;
    check("t5_grant_after_rst", 32'(grant), 32'd0);
    check("t5_xout_after_rst",  32'(x_out), 32'd0);
    check("t5_xcycles", 32'(x_total - x0), 32'd2);
    check("t5_no_done", 32'(done_tot[0] - d0), 32'd0);
    q0 = done_q.size();
    set_len(0, 2); set_len(1, 2); req = 4'b0011;
    tick(5); req = '0;
    tick(6);
    check("t5_bursts", 32'(done_q.size() - q0), 32'd2);
    if (done_q.size() >= q0 + 2) begin
      check("t5_first",  32'(done_q[q0]),     32'd0);
      check("t5_second", 32'(done_q[q0 + 1]), 32'd1);
    end

    // Request dropped and length changed mid-burst; then maximum length.
    x0 = x_total; d0 = done_tot[0];
    set_len(0, 4); req = 4'b0001;
    tick(1); req = '0; set_len(0, 9);
    tick(7);
    check("t6_xcycles", 32'(x_total - x0), 32'd4);
    check("t6_done0",   32'(done_tot[0] - d0), 32'd1);
    x0 = x_total; d0 = done_tot[0];
    set_len(0, 15); req = 4'b0001;
    tick(1); req = '0;
    tick(18);
    check("t6_max_xcycles", 32'(x_total - x0), 32'd15);
    check("t6_max_done0",   32'(done_tot[0] - d0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
